// File: rtl/cnn_layer_sequencer_if.sv
// Host/datapath bundle for the CNN layer sequencer.
// master = host plus Top_layer datapath, slave = the sequencer itself.
interface cnn_layer_sequencer_if #(
   parameter int IMG_W  = 4,
   parameter int F1_W   = 4,
   parameter int F2_W   = 10,
   parameter int RES_W  = 22,
   parameter int ADDR_W = 4
);
   // configuration port
   logic              cfg_we;
   logic [1:0]        cfg_sel;
   logic [ADDR_W-1:0] cfg_addr;
   logic [F2_W-1:0]   cfg_wdata;
   logic              cfg_err;
   // run control / status
   logic              go;
   logic              abort;
   logic              busy;
   logic              done;
   logic [RES_W-1:0]  result;
   logic              result_valid;
   // datapath side
   logic              start1;
   logic              read_en1;
   logic              start2;
   logic              read_en2;
   logic [IMG_W-1:0]  image;
   logic [F1_W-1:0]   filter1;
   logic [F2_W-1:0]   filter2;
   logic [RES_W-1:0]  conv_result;

   modport master (
      output cfg_we, cfg_sel, cfg_addr, cfg_wdata, go, abort, conv_result,
      input  cfg_err, busy, done, result, result_valid,
             start1, read_en1, start2, read_en2, image, filter1, filter2
   );

   modport slave (
      input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, go, abort, conv_result,
      output cfg_err, busy, done, result, result_valid,
             start1, read_en1, start2, read_en2, image, filter1, filter2
   );
endinterface

// File: rtl/cnn_layer_sequencer.sv
// Deterministic controller for one two-layer CNN inference.
// Streams image/filter1 taps, waits out layer-1 latency, streams filter2 taps,
// waits out layer-2 latency, then captures ConvResult.
module cnn_layer_sequencer #(
   parameter int N_TAPS = 15,
   parameter int IMG_W  = 4,
   parameter int F1_W   = 4,
   parameter int F2_W   = 10,
   parameter int RES_W  = 22,
   parameter int L1_LAT = 2,
   parameter int L2_LAT = 3
) (
   input  logic                   clk,
   input  logic                   rst_n,
   cnn_layer_sequencer_if.slave   bus
);

   localparam int ADDR_W  = 4;
   // one counter serves beat index and both latency waits
   localparam int CNT_MAX = (N_TAPS >= L1_LAT) ?
                            ((N_TAPS >= L2_LAT) ? N_TAPS : L2_LAT) :
                            ((L1_LAT >= L2_LAT) ? L1_LAT : L2_LAT);
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_S1,
      ST_F1,
      ST_W1,
      ST_S2,
      ST_F2,
      ST_W2
   } state_t;

   state_t                          state_q;
   logic [CNT_W-1:0]                cnt_q;
   logic                            done_q;
   logic                            cfg_err_q;
   logic [RES_W-1:0]                result_q;
   logic                            result_valid_q;

   // coefficient stores: never reset, they survive reset and aborts
   logic [N_TAPS-1:0][IMG_W-1:0]    img_q;
   logic [N_TAPS-1:0][F1_W-1:0]     f1_q;
   logic [N_TAPS-1:0][F2_W-1:0]     f2_q;

   logic                            cfg_ok;
   logic                            last_tap;
   logic                            start1_c, read_en1_c, start2_c, read_en2_c;
   logic [IMG_W-1:0]                image_c;
   logic [F1_W-1:0]                 filter1_c;
   logic [F2_W-1:0]                 filter2_c;

   // a write lands only while idle, to a real store, at an in-range tap
   assign cfg_ok   = bus.cfg_we && (state_q == ST_IDLE) && (bus.cfg_sel != 2'd3) &&
                     ({1'b0, bus.cfg_addr} < (ADDR_W+1)'(N_TAPS));
   assign last_tap = (cnt_q == CNT_W'(N_TAPS - 1));

   // commit accepted configuration writes into the selected store
   always_ff @(posedge clk) begin
      if (cfg_ok) begin
         case (bus.cfg_sel)
            2'd0:    img_q[bus.cfg_addr] <= bus.cfg_wdata[IMG_W-1:0];
            2'd1:    f1_q[bus.cfg_addr]  <= bus.cfg_wdata[F1_W-1:0];
            2'd2:    f2_q[bus.cfg_addr]  <= bus.cfg_wdata[F2_W-1:0];
            default: ;
         endcase
      end
   end

   // sequencing FSM with registered status outputs; abort beats every step
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         cnt_q          <= '0;
         done_q         <= 1'b0;
         cfg_err_q      <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         cfg_err_q <= bus.cfg_we && !cfg_ok;
         cnt_q     <= cnt_q + 1'b1;
         if ((state_q != ST_IDLE) && bus.abort) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  cnt_q <= '0;
                  if (bus.go) begin
                     state_q        <= ST_S1;
                     result_valid_q <= 1'b0;
                  end
               end
               ST_S1: begin
                  if (last_tap) begin
                     state_q <= ST_F1;
                     cnt_q   <= '0;
                  end
               end
               ST_F1: begin
                  state_q <= ST_W1;
                  cnt_q   <= '0;
               end
               ST_W1: begin
                  if (cnt_q == CNT_W'(L1_LAT - 1)) begin
                     state_q <= ST_S2;
                     cnt_q   <= '0;
                  end
               end
               ST_S2: begin
                  if (last_tap) begin
                     state_q <= ST_F2;
                     cnt_q   <= '0;
                  end
               end
               ST_F2: begin
                  state_q <= ST_W2;
                  cnt_q   <= '0;
               end
               ST_W2: begin
                  if (cnt_q == CNT_W'(L2_LAT - 1)) begin
                     state_q        <= ST_IDLE;
                     cnt_q          <= '0;
                     result_q       <= bus.conv_result;
                     result_valid_q <= 1'b1;
                     done_q         <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_IDLE;
                  cnt_q   <= '0;
               end
            endcase
         end
      end
   end

   // datapath controls decode from registered state so reset zeroes them at once
   always_comb begin
      start1_c   = 1'b0;
      read_en1_c = 1'b0;
      start2_c   = 1'b0;
      read_en2_c = 1'b0;
      image_c    = '0;
      filter1_c  = '0;
      filter2_c  = '0;
      case (state_q)
         ST_S1: begin
            start1_c  = 1'b1;
            image_c   = img_q[cnt_q];
            filter1_c = f1_q[cnt_q];
         end
         ST_W1, ST_F2: read_en1_c = 1'b1;
         ST_S2: begin
            read_en1_c = 1'b1;
            start2_c   = 1'b1;
            filter2_c  = f2_q[cnt_q];
         end
         ST_W2: begin
            read_en1_c = 1'b1;
            read_en2_c = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.busy         = (state_q != ST_IDLE);
   assign bus.done         = done_q;
   assign bus.cfg_err      = cfg_err_q;
   assign bus.result       = result_q;
   assign bus.result_valid = result_valid_q;
   assign bus.start1       = start1_c;
   assign bus.read_en1     = read_en1_c;
   assign bus.start2       = start2_c;
   assign bus.read_en2     = read_en2_c;
   assign bus.image        = image_c;
   assign bus.filter1      = filter1_c;
   assign bus.filter2      = filter2_c;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// Self-checking bench for cnn_layer_sequencer: per-cycle expected output
// vectors are queued from a cycle-number schedule model and popped as the
// DUT runs each inference.
module tb_cnn_layer_sequencer;
   localparam int N_TAPS = 15;
   localparam int L1_LAT = 2;
   localparam int L2_LAT = 3;
   localparam int RES_W  = 22;

   // schedule in cycles after go (go sampled at the end of cycle 0)
   localparam int S1_E   = N_TAPS;
   localparam int W1_S   = N_TAPS + 2;
   localparam int S2_S   = W1_S + L1_LAT;
   localparam int S2_E   = S2_S + N_TAPS - 1;
   localparam int W2_S   = S2_E + 2;
   localparam int W2_E   = W2_S + L2_LAT - 1;
   localparam int DONE_C = W2_E + 1;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       rv;
      logic       cfg_err;
      logic       start1;
      logic       read_en1;
      logic       start2;
      logic       read_en2;
      logic [3:0] image;
      logic [3:0] filter1;
      logic [9:0] filter2;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cnn_layer_sequencer_if #(.IMG_W(4), .F1_W(4), .F2_W(10), .RES_W(RES_W), .ADDR_W(4)) bus();

   cnn_layer_sequencer #(
      .N_TAPS(N_TAPS), .IMG_W(4), .F1_W(4), .F2_W(10), .RES_W(RES_W),
      .L1_LAT(L1_LAT), .L2_LAT(L2_LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   int errors = 0;
   int checks = 0;
   obs_t sb[$];

   int img_v[15] = '{1, 2, 3, 2, 3, 4, 3, 4, 5, 4, 5, 6, 5, 6, 7};
   int f1_v[15]  = '{1, 2, 3, -3, -2, -1, 1, 2, 3, -5, 5, -7, 1, 2, 3};
   int f2_v[15]  = '{1, 2, 3, -1, -2, -3, 4, 5, 6, -4, -5, -6, 7, 8, 9};
   logic [3:0] img_m[15];
   logic [3:0] f1_m[15];
   logic [9:0] f2_m[15];
   logic [RES_W-1:0] res_a;
   logic [RES_W-1:0] res_b;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic obs_t sample();
      obs_t o;
      o.busy     = bus.busy;
      o.done     = bus.done;
      o.rv       = bus.result_valid;
      o.cfg_err  = bus.cfg_err;
      o.start1   = bus.start1;
      o.read_en1 = bus.read_en1;
      o.start2   = bus.start2;
      o.read_en2 = bus.read_en2;
      o.image    = bus.image;
      o.filter1  = bus.filter1;
      o.filter2  = bus.filter2;
      return o;
   endfunction

   // expected outputs in cycle c; negative event cycles mean "does not happen"
   function automatic obs_t model(int c, int abort_c, int we_c, int rst_c);
      obs_t e;
      bit   live;
      bit   in_rst;
      e      = '0;
      in_rst = (rst_c >= 0) && (c >= rst_c);
      live   = ((abort_c < 0) || (c <= abort_c)) && !in_rst;
      if (live) begin
         e.busy     = (c >= 1) && (c <= W2_E);
         e.done     = (c == DONE_C);
         e.rv       = (c >= DONE_C);
         e.start1   = (c >= 1) && (c <= S1_E);
         e.read_en1 = (c >= W1_S) && (c <= W2_E);
         e.start2   = (c >= S2_S) && (c <= S2_E);
         e.read_en2 = (c >= W2_S) && (c <= W2_E);
         if (e.start1) begin
            e.image   = img_m[c-1];
            e.filter1 = f1_m[c-1];
         end
         if (e.start2) e.filter2 = f2_m[c-S2_S];
      end
      e.cfg_err = (we_c >= 0) && (c == we_c + 1) && !in_rst;
      return e;
   endfunction

   // one inference: go in cycle 0, then cycles 1..last_c checked against the queue
   task automatic run_seq(input int abort_c, input int go_c, input int we_c,
                          input int rst_c, input int last_c);
      obs_t e;
      obs_t o;
      for (int c = 1; c <= last_c; c++) sb.push_back(model(c, abort_c, we_c, rst_c));
      bus.go = 1'b1;
      tick();
      bus.go     = 1'b0;
      bus.cfg_we = 1'b0;
      for (int c = 1; c <= last_c; c++) begin
         if (c == rst_c) begin
            #2 rst_n = 1'b0;
            #1;
         end
         e = sb.pop_front();
         o = sample();
         checks++;
         if (o !== e) begin
            errors++;
            $display("FAIL trace cycle=%0d got=%h expected=%h", c, o, e);
         end
         bus.abort = (c == abort_c);
         bus.go    = (c == go_c);
         if (c == we_c) begin
            bus.cfg_we    = 1'b1;
            bus.cfg_sel   = 2'd0;
            bus.cfg_addr  = 4'd0;
            bus.cfg_wdata = 10'd15;
         end else begin
            bus.cfg_we = 1'b0;
         end
         tick();
      end
      bus.abort  = 1'b0;
      bus.go     = 1'b0;
      bus.cfg_we = 1'b0;
   endtask

   task automatic cfg_write(input logic [1:0] sel, input logic [3:0] addr,
                            input logic [9:0] data, input logic exp_err);
      bus.cfg_we    = 1'b1;
      bus.cfg_sel   = sel;
      bus.cfg_addr  = addr;
      bus.cfg_wdata = data;
      tick();
      bus.cfg_we = 1'b0;
      checks++;
      if (bus.cfg_err !== exp_err) begin
         errors++;
         $display("FAIL cfg_err sel=%0d addr=%0d got=%b expected=%b", sel, addr, bus.cfg_err, exp_err);
      end
      if (exp_err) begin
         tick();
         checks++;
         if (bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL cfg_err_pulse got=%b expected=0", bus.cfg_err);
         end
      end
   endtask

   task automatic check_result(input string name, input logic [RES_W-1:0] exp_r, input logic exp_v);
      checks++;
      if (bus.result !== exp_r || bus.result_valid !== exp_v) begin
         errors++;
         $display("FAIL %s result=%h valid=%b expected result=%h valid=%b",
                  name, bus.result, bus.result_valid, exp_r, exp_v);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      checks++;
      if (sample() !== obs_t'(0)) begin
         errors++;
         $display("FAIL reset_outputs got=%h expected=0", sample());
      end
      check_result("reset_result", '0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_load();
      for (int i = 0; i < N_TAPS; i++) begin
         img_m[i] = 4'(img_v[i]);
         f1_m[i]  = 4'(f1_v[i]);
         f2_m[i]  = 10'(f2_v[i]);
         cfg_write(2'd0, 4'(i), {6'd0, img_m[i]}, 1'b0);
         cfg_write(2'd1, 4'(i), {6'd0, f1_m[i]}, 1'b0);
         cfg_write(2'd2, 4'(i), f2_m[i], 1'b0);
      end
   endtask

   task automatic test_full_run();
      bus.conv_result = res_a;
      run_seq(-1, -1, -1, -1, DONE_C + 1);
      check_result("full_run", res_a, 1'b1);
   endtask

   task automatic test_abort();
      bus.conv_result = res_b;
      run_seq(10, -1, -1, -1, 24);
      check_result("abort_keeps_result", res_a, 1'b0);
      bus.conv_result = res_a;
   endtask

   task automatic test_busy_ignore();
      run_seq(-1, 5, 7, -1, DONE_C + 1);
      check_result("busy_ignore", res_a, 1'b1);
   endtask

   task automatic test_same_cycle_write();
      bus.cfg_we    = 1'b1;
      bus.cfg_sel   = 2'd0;
      bus.cfg_addr  = 4'd0;
      bus.cfg_wdata = 10'd9;
      img_m[0]      = 4'd9;
      run_seq(-1, -1, -1, -1, DONE_C + 1);
      check_result("same_cycle_write", res_a, 1'b1);
      cfg_write(2'd0, 4'd15, 10'd3, 1'b1);
      cfg_write(2'd3, 4'd0, 10'd1, 1'b1);
   endtask

   task automatic test_reset_mid();
      run_seq(-1, -1, -1, 20, 22);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (sample() !== obs_t'(0)) begin
            errors++;
            $display("FAIL idle_after_reset got=%h expected=0", sample());
         end
      end
      check_result("reset_mid_result", '0, 1'b0);
      run_seq(-1, -1, -1, -1, DONE_C + 1);
      check_result("rerun_after_reset", res_a, 1'b1);
   endtask

   initial begin
      res_a           = RES_W'(-1234);
      res_b           = RES_W'(555);
      bus.cfg_we      = 1'b0;
      bus.cfg_sel     = 2'd0;
      bus.cfg_addr    = 4'd0;
      bus.cfg_wdata   = '0;
      bus.go          = 1'b0;
      bus.abort       = 1'b0;
      bus.conv_result = res_a;
      test_reset();
      test_load();
      test_full_run();
      test_abort();
      test_busy_ignore();
      test_same_cycle_write();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
